rec_stream_reader: RTL and testbench

Parametrised Avalon-MM record fetcher, the successor to the single-triangle reader. It streams `count` consecutive fixed-size records, e.g. 9-word triangles or 7-word ray headers, out of SDRAM. Bus width, record size and read pipelining depth are parameters. Each assembled record is handed to the consumer (triangle intersector, ray tracer control) over a valid/ready handshake, with a per-record index and last flag.

---
 rtl/rec_stream_reader.sv | 220 ++++++++++++++++++++++
 tb/tb_rec_stream_reader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rec_stream_reader.sv
// rec_stream_reader: fetches `count` consecutive fixed-size records from an
// Avalon-MM slave. It reads BUS_W-bit beats with up to MAX_PEND reads in
// flight, assembles each record and hands it over with valid/ready.
//
// state  | meaning
// IDLE   | waiting for a request, iready=1
// FETCH  | issuing and collecting the beats of the current record
// HOLD   | record presented on rec_data, waiting for rec_ready
// DONE   | one-cycle done pulse, then back to IDLE
module rec_stream_reader #(
  parameter int BUS_W    = 16,
  parameter int WORD_W   = 32,
  parameter int NWORDS   = 9,
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              baseaddr,
  input  logic [31:0]              index,
  input  logic [CNT_W-1:0]         count,
  input  logic                     ivalid,
  output logic                     iready,
  output logic [NWORDS*WORD_W-1:0] rec_data,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W-1:0]         rec_num,
  output logic                     rec_last,
  output logic                     done,
  output logic                     err,
  output logic                     avm_m0_read,
  output logic [31:0]              avm_m0_address,
  output logic [BUS_W/8-1:0]       avm_m0_byteenable,
  output logic                     avm_m0_write,
  output logic [BUS_W-1:0]         avm_m0_writedata,
  input  logic [BUS_W-1:0]         avm_m0_readdata,
  input  logic                     avm_m0_readdatavalid,
  input  logic                     avm_m0_waitrequest
);

  localparam int REC_BITS   = NWORDS * WORD_W;
  localparam int BEATS      = REC_BITS / BUS_W;
  localparam int RECBYTES   = REC_BITS / 8;
  localparam int BEAT_BYTES = BUS_W / 8;
  // counters must hold both BEATS and MAX_PEND
  localparam int CMAX       = (BEATS > MAX_PEND) ? BEATS : MAX_PEND;
  localparam int CW         = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BEATS_C      = CW'(BEATS);
  localparam logic [CW-1:0] MAX_PEND_C   = CW'(MAX_PEND);
  localparam logic [31:0]   RECBYTES_C   = 32'(RECBYTES);
  localparam logic [31:0]   BEAT_BYTES_C = 32'(BEAT_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_iready;
  logic                r_valid;
  logic                r_last;
  logic                r_done;
  logic                r_err;
  logic                r_read;
  logic [31:0]         r_addr;
  logic [REC_BITS-1:0] r_data;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    r_rec;
  logic [CNT_W-1:0]    r_num;
  logic [CW-1:0]       r_issued;
  logic [CW-1:0]       r_received;

  logic [CW-1:0]       w_pend;
  logic                w_issue;
  logic                w_ret_ok;
  logic                w_stray;
  logic [CW-1:0]       w_issued_nx;
  logic [CW-1:0]       w_received_nx;
  logic [CW-1:0]       w_pend_nx;
  logic                w_read_nx;
  logic                w_is_last;

  // Bus bookkeeping: what this edge issues/returns and the read request that follows.
  always_comb begin
    w_pend        = r_issued - r_received;
    w_issue       = r_read & ~avm_m0_waitrequest;
    w_ret_ok      = avm_m0_readdatavalid & (r_state == S_FETCH) & (w_pend != '0);
    w_stray       = avm_m0_readdatavalid &
                    (((r_state == S_FETCH) & (w_pend == '0)) |
                     (r_state == S_HOLD) | (r_state == S_DONE));
    w_issued_nx   = r_issued + CW'(w_issue);
    w_received_nx = r_received + CW'(w_ret_ok);
    w_pend_nx     = w_issued_nx - w_received_nx;
    w_read_nx     = (w_issued_nx < BEATS_C) && (w_pend_nx < MAX_PEND_C);
    w_is_last     = (r_rec == (r_count - CNT_W'(1)));
  end

  // Request sequencing, beat issue/collection and record handoff.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_iready   <= 1'b1;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_read     <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_count    <= '0;
      r_rec      <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_received <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ivalid) begin
            r_iready   <= 1'b0;
            r_err      <= 1'b0;
            r_rec      <= '0;
            r_issued   <= '0;
            r_received <= '0;
            r_count    <= count;
            // the address register then simply walks through every beat
            r_addr     <= baseaddr + index * RECBYTES_C;
            if (count == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FETCH;
              r_read  <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (w_issue) begin
            r_addr <= r_addr + BEAT_BYTES_C;
          end
          r_issued   <= w_issued_nx;
          r_received <= w_received_nx;
          if (w_ret_ok) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_received == CW'(k)) begin
                r_data[k*BUS_W +: BUS_W] <= avm_m0_readdata;
              end
            end
          end
          if (w_stray) begin
            r_err <= 1'b1;
          end
          if (w_received_nx == BEATS_C) begin
            r_state <= S_HOLD;
            r_read  <= 1'b0;
            r_valid <= 1'b1;
            r_num   <= r_rec;
            r_last  <= w_is_last;
          end else begin
            r_read <= w_read_nx;
          end
        end

        S_HOLD: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          if (rec_ready) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            if (r_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_rec      <= r_rec + CNT_W'(1);
              r_issued   <= '0;
              r_received <= '0;
              r_state    <= S_FETCH;
              r_read     <= 1'b1;
            end
          end
        end

        S_DONE: begin
          if (w_stray) begin
            r_err <= 1'b1;
          end
          r_done   <= 1'b0;
          r_iready <= 1'b1;
          r_state  <= S_IDLE;
        end

        default: begin
          r_state  <= S_IDLE;
          r_iready <= 1'b1;
          r_read   <= 1'b0;
          r_valid  <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign iready            = r_iready;
  assign rec_data          = r_data;
  assign rec_valid         = r_valid;
  assign rec_num           = r_num;
  assign rec_last          = r_last;
  assign done              = r_done;
  assign err               = r_err;
  assign avm_m0_read       = r_read;
  assign avm_m0_address    = r_addr;
  assign avm_m0_byteenable = '1;
  assign avm_m0_write      = 1'b0;
  assign avm_m0_writedata  = '0;

endmodule

// File: tb/tb_rec_stream_reader.sv
// Bench for rec_stream_reader with default parameters: an Avalon slave model
// with configurable latency and random waitrequest, a consumer/monitor that
// checks each presented record against a queue of expected records.
module tb_rec_stream_reader;

  localparam int BUS_W    = 16;
  localparam int WORD_W   = 32;
  localparam int NWORDS   = 9;
  localparam int MAX_PEND = 4;
  localparam int CNT_W    = 16;
  localparam int REC_BITS = NWORDS * WORD_W;
  localparam int BEATS    = 18;
  localparam int RECBYTES = 36;

  logic                clk;
  logic                reset;
  logic [31:0]         baseaddr;
  logic [31:0]         index;
  logic [CNT_W-1:0]    count;
  logic                ivalid;
  logic                iready;
  logic [REC_BITS-1:0] rec_data;
  logic                rec_valid;
  logic                rec_ready;
  logic [CNT_W-1:0]    rec_num;
  logic                rec_last;
  logic                done;
  logic                err;
  logic                avm_m0_read;
  logic [31:0]         avm_m0_address;
  logic [1:0]          avm_m0_byteenable;
  logic                avm_m0_write;
  logic [15:0]         avm_m0_writedata;
  logic [15:0]         avm_m0_readdata;
  logic                avm_m0_readdatavalid;
  logic                avm_m0_waitrequest;

  rec_stream_reader #(
    .BUS_W(BUS_W), .WORD_W(WORD_W), .NWORDS(NWORDS), .MAX_PEND(MAX_PEND), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .baseaddr(baseaddr), .index(index), .count(count),
    .ivalid(ivalid), .iready(iready), .rec_data(rec_data), .rec_valid(rec_valid),
    .rec_ready(rec_ready), .rec_num(rec_num), .rec_last(rec_last), .done(done), .err(err),
    .avm_m0_read(avm_m0_read), .avm_m0_address(avm_m0_address),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_write(avm_m0_write),
    .avm_m0_writedata(avm_m0_writedata), .avm_m0_readdata(avm_m0_readdata),
    .avm_m0_readdatavalid(avm_m0_readdatavalid), .avm_m0_waitrequest(avm_m0_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [REC_BITS-1:0] data;
    logic [CNT_W-1:0]    num;
    logic                last;
  } rec_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } rd_t;

  int total = 0;
  int bad   = 0;

  rec_t        exp_q[$];
  rd_t         rd_q[$];
  logic [31:0] base_q[$];
  int          lat = 2;
  int          wait_pct = 0;
  int          hold_cycles = 0;
  bit          inject_stray = 0;
  int          edge_n = 0;
  int          outstanding = 0;
  int          max_out = 0;
  int          req_reads = 0;
  int          done_cnt = 0;
  logic [31:0] first_addr = '0;
  logic [31:0] last_addr = '0;

  function automatic logic [15:0] mem16(input logic [31:0] a);
    logic [15:0] m;
    m = a[15:0] * 16'd40503;
    return m ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [REC_BITS-1:0] act,
                       input logic [REC_BITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Avalon slave: returns mem16(addr) lat edges after each accepted read
  initial begin
    rd_t  t;
    logic prev_stall;
    logic [31:0] prev_addr;
    prev_stall = 1'b0;
    prev_addr = '0;
    avm_m0_waitrequest = 1'b0;
    avm_m0_readdatavalid = 1'b0;
    avm_m0_readdata = '0;
    forever begin
      @(negedge clk);
      edge_n++;
      avm_m0_readdatavalid = 1'b0;
      avm_m0_readdata = '0;
      if (rd_q.size() > 0 && rd_q[0].due <= edge_n) begin
        t = rd_q.pop_front();
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = mem16(t.addr);
        outstanding--;
      end else if (inject_stray && rec_valid) begin
        avm_m0_readdatavalid = 1'b1;
        avm_m0_readdata = 16'hDEAD;
        inject_stray = 0;
      end
      if (prev_stall) begin
        check("read_held", avm_m0_read, 1'b1);
        check("addr_held", avm_m0_address, prev_addr);
      end
      avm_m0_waitrequest = (wait_pct > 0) && ($urandom_range(0, 99) < wait_pct);
      if (avm_m0_read && !avm_m0_waitrequest) begin
        rd_q.push_back('{due: edge_n + lat, addr: avm_m0_address});
        outstanding++;
        if (outstanding > max_out) max_out = outstanding;
        if (req_reads % BEATS == 0) base_q.push_back(avm_m0_address);
        if (req_reads == 0) first_addr = avm_m0_address;
        last_addr = avm_m0_address;
        req_reads++;
      end
      prev_stall = avm_m0_read && avm_m0_waitrequest;
      prev_addr = avm_m0_address;
    end
  end

  // Consumer and monitor: delays rec_ready, pops and compares on each handoff
  initial begin
    rec_t e;
    int   hold_cnt;
    bit   read_in_hold;
    bit   prev_done;
    hold_cnt = 0;
    read_in_hold = 0;
    prev_done = 0;
    rec_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        check("done_width", done, 1'b0);
        check("iready_after_done", iready, 1'b1);
      end
      prev_done = done;
      if (done) done_cnt++;
      if (rec_valid) begin
        if (avm_m0_read) read_in_hold = 1;
        if (hold_cnt < hold_cycles) begin
          hold_cnt++;
          rec_ready = 1'b0;
        end else begin
          rec_ready = 1'b1;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_record: got rec_num=%0d expected none", rec_num);
          end else begin
            e = exp_q.pop_front();
            check("rec_data", rec_data, e.data);
            check("rec_num", rec_num, e.num);
            check("rec_last", rec_last, e.last);
            check("no_read_in_hold", read_in_hold, 1'b0);
          end
          hold_cnt = 0;
          read_in_hold = 0;
        end
      end else begin
        rec_ready = 1'b0;
        hold_cnt = 0;
        read_in_hold = 0;
      end
    end
  end

  task automatic push_expected(input logic [31:0] b, input logic [31:0] idx,
                               input int cnt);
    rec_t        e;
    logic [31:0] rb;
    for (int r = 0; r < cnt; r++) begin
      rb = b + (idx + 32'(r)) * 32'(RECBYTES);
      for (int k = 0; k < BEATS; k++) begin
        e.data[k*16 +: 16] = mem16(rb + 32'(k * 2));
      end
      e.num = CNT_W'(r);
      e.last = (r == cnt - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_req(input logic [31:0] b, input logic [31:0] idx,
                           input logic [CNT_W-1:0] cnt);
    int n;
    n = 0;
    @(negedge clk);
    while (!iready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("iready_before_req", iready, 1'b1);
    req_reads = 0;
    base_q.delete();
    done_cnt = 0;
    baseaddr = b;
    index = idx;
    count = cnt;
    ivalid = 1'b1;
    @(negedge clk);
    ivalid = 1'b0;
    check("read_after_accept", avm_m0_read, cnt != 0);
    if (cnt == 0) check("done_after_accept", done, 1'b1);
  endtask

  task automatic run_req(input logic [31:0] b, input logic [31:0] idx,
                         input logic [CNT_W-1:0] cnt, input logic exp_err);
    int n;
    push_expected(b, idx, int'(cnt));
    start_req(b, idx, cnt);
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end
    @(negedge clk);
    @(negedge clk);
    check("done_count", done_cnt, 1);
    check("err_end", err, exp_err);
    check("records_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    baseaddr = '0;
    index = '0;
    count = '0;
    ivalid = 1'b0;
    #3 reset = 1'b0;
    #4;
    check("rst_iready", iready, 1'b1);
    check("rst_valid", rec_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_read", avm_m0_read, 1'b0);
    check("rst_addr", avm_m0_address, 32'h0);
    check("rst_data", rec_data, '0);
    check("rst_num_last", {rec_num, rec_last}, '0);
    check("tie_off", {avm_m0_byteenable, avm_m0_write, avm_m0_writedata}, {2'b11, 1'b0, 16'h0});
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // single record, L=2, no wait: 0x1000 + 2*36 = 0x1048 .. 0x106A
    lat = 2; wait_pct = 0; hold_cycles = 0;
    run_req(32'h1000, 32'd2, 16'd1, 1'b0);
    check("A_reads", req_reads, 18);
    check("A_first_addr", first_addr, 32'h1048);
    check("A_last_addr", last_addr, 32'h106A);

    // three records, consumer stalls 5 cycles each: bases 0x2000 + 10*36 = 0x2168
    hold_cycles = 5;
    run_req(32'h2000, 32'd10, 16'd3, 1'b0);
    check("B_reads", req_reads, 54);
    check("B_nbase", base_q.size(), 3);
    if (base_q.size() == 3) begin
      check("B_base0", base_q[0], 32'h2168);
      check("B_base1", base_q[1], 32'h218C);
      check("B_base2", base_q[2], 32'h21B0);
    end

    // L=6, no wait: reads throttle at exactly MAX_PEND
    lat = 6; hold_cycles = 0; max_out = 0;
    run_req(32'h0, 32'd0, 16'd2, 1'b0);
    check("C_max_pend_reached", max_out, MAX_PEND);

    // L=6 with random waitrequest, including an address wrap past 2^32
    wait_pct = 40; max_out = 0;
    run_req(32'h3000, 32'd7, 16'd2, 1'b0);
    run_req(32'hFFFF_FFE0, 32'd0, 16'd2, 1'b0);
    check("C_max_pend_bound", max_out <= MAX_PEND, 1'b1);
    check("C_wrap_first", first_addr, 32'hFFFF_FFE0);

    // count=0: no bus traffic
    wait_pct = 0; lat = 2;
    run_req(32'h1000, 32'd5, 16'd0, 1'b0);
    check("D_reads", req_reads, 0);

    // stray return while a record is held
    hold_cycles = 5; inject_stray = 1;
    run_req(32'h4000, 32'd1, 16'd1, 1'b1);
    check("E_stray_used", inject_stray, 1'b0);
    hold_cycles = 0;
    run_req(32'h4000, 32'd2, 16'd1, 1'b0);

    // reset with three reads in flight
    lat = 6;
    start_req(32'h5000, 32'd0, 16'd2);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (req_reads < 3 && n < 50);
    check("F_pending", outstanding, 3);
    reset = 1'b0;
    #1;
    check("F_iready", iready, 1'b1);
    check("F_read", avm_m0_read, 1'b0);
    check("F_addr", avm_m0_address, 32'h0);
    check("F_data", rec_data, '0);
    check("F_flags", {rec_valid, done, err}, 3'b000);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    n = 0;
    while (outstanding > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("F_drained", outstanding, 0);
    check("F_late_err", err, 1'b0);
    run_req(32'h5000, 32'd0, 16'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
